pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential increment, stall hold, and
// branch/trap redirection with capture of redirects that arrive during a stall.
// All state advances on the falling edge of CLK.
module pc_sequencer #(
  parameter int unsigned     SIZE         = 32,
  parameter int unsigned     STEP         = 4,
  parameter logic [SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [SIZE-1:0] TRAP_VECTOR  = SIZE'(32'h0000_0100)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallF,
  input  logic            BranchTakenE,
  input  logic [SIZE-1:0] BranchTargetE,
  input  logic            TrapReq,
  output logic [SIZE-1:0] PCF,
  output logic [SIZE-1:0] PCPlusStepF,
  output logic            RedirectPending,
  output logic            MisalignF
);

  localparam logic [SIZE-1:0] STEP_V     = SIZE'(STEP);
  localparam logic [SIZE-1:0] ALIGN_MASK = SIZE'(STEP - 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] pend_q, pend_d;
  logic            pend_trap_q, pend_trap_d;
  logic            mis_q, mis_d;

  logic [SIZE-1:0] br_tgt;
  logic            br_mis;
  logic [SIZE-1:0] hold_tgt;
  logic            hold_trap;

  // State register, synchronous reset on the falling edge
  always_ff @(negedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      pend_q      <= '0;
      pend_trap_q <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_trap_q <= pend_trap_d;
      mis_q       <= mis_d;
    end
  end

  // Next-state logic: trap beats branch, branch beats pending, pending beats stall
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_trap_d = pend_trap_q;
    mis_d       = 1'b0;
    br_tgt      = BranchTargetE & ~ALIGN_MASK;
    br_mis      = |(BranchTargetE & ALIGN_MASK);
    hold_tgt    = pend_q;
    hold_trap   = pend_trap_q;

    unique case (state_q)
      RUN: begin
        if (TrapReq) begin
          if (StallF) begin
            pend_d      = TRAP_VECTOR;
            pend_trap_d = 1'b1;
            state_d     = HOLD;
          end else begin
            pc_d = TRAP_VECTOR;
          end
        end else if (BranchTakenE) begin
          mis_d = br_mis;
          if (StallF) begin
            pend_d      = br_tgt;
            pend_trap_d = 1'b0;
            state_d     = HOLD;
          end else begin
            pc_d = br_tgt;
          end
        end else if (!StallF) begin
          pc_d = pc_q + STEP_V;
        end
      end
      HOLD: begin
        // A fresh redirect updates the candidate first; a pending trap is sticky against branches
        if (TrapReq) begin
          hold_tgt  = TRAP_VECTOR;
          hold_trap = 1'b1;
        end else if (BranchTakenE && !pend_trap_q) begin
          hold_tgt  = br_tgt;
          hold_trap = 1'b0;
          mis_d     = br_mis;
        end
        if (StallF) begin
          pend_d      = hold_tgt;
          pend_trap_d = hold_trap;
        end else begin
          pc_d        = hold_tgt;
          pend_d      = '0;
          pend_trap_d = 1'b0;
          state_d     = RUN;
        end
      end
    endcase
  end

  assign PCF             = pc_q;
  assign PCPlusStepF     = pc_q + STEP_V;
  assign RedirectPending = (state_q == HOLD);
  assign MisalignF       = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        StallF = 1'b0;
  logic        BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = '0;
  logic        TrapReq = 1'b0;
  logic [31:0] PCF;
  logic [31:0] PCPlusStepF;
  logic        RedirectPending;
  logic        MisalignF;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .SIZE(32),
    .STEP(4),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR(32'h0000_0100)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .StallF(StallF),
    .BranchTakenE(BranchTakenE),
    .BranchTargetE(BranchTargetE),
    .TrapReq(TrapReq),
    .PCF(PCF),
    .PCPlusStepF(PCPlusStepF),
    .RedirectPending(RedirectPending),
    .MisalignF(MisalignF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the falling edge happen, then sample
  task automatic apply(input logic rst, input logic stall, input logic br,
                       input logic [31:0] tgt, input logic trap);
    RESET         = rst;
    StallF        = stall;
    BranchTakenE  = br;
    BranchTargetE = tgt;
    TrapReq       = trap;
    @(negedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic pend, input logic mis);
    check32({tag, " PCF"}, PCF, pc);
    check32({tag, " PCPlusStepF"}, PCPlusStepF, pc + 32'd4);
    check1({tag, " RedirectPending"}, RedirectPending, pend);
    check1({tag, " MisalignF"}, MisalignF, mis);
  endtask

  initial begin
    //                rst  stall br   tgt            trap exp_pc         pend mis
    vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b0, 1'b0});
    // stall two cycles at 0x10, then release
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0010, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0014, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0018, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_001C, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 1'b0, 1'b0});
    // branch captured under stall, stall held, then released
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0000_0020, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0020, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0080, 1'b0, 1'b0});
    // pending trap is not displaced by a later branch
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0100, 1'b0, 1'b0});
    // misaligned immediate branch: aligned target, one-cycle flag
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h46,       1'b0, 32'h0000_0044, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0048, 1'b0, 1'b0});
    // simultaneous trap and branch: trap wins
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 32'h0000_0100, 1'b0, 1'b0});
    // misaligned captured branch, then replaced by an aligned one, then new branch on release
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h47,       1'b0, 32'h0000_0100, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h60,       1'b0, 32'h0000_0100, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h30,       1'b0, 32'h0000_0030, 1'b0, 1'b0});
    // reset while holding discards the pending redirect
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h90,       1'b0, 32'h0000_0030, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b0, 1'b0});
    // wrap at the top of the address space
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 1'b0});
    // trap in HOLD overwrites a pending branch
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0100, 1'b0, 1'b0});
    // pending trap survives a branch arriving on the release cycle
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h50,       1'b0, 32'h0000_0100, 1'b0, 1'b0});
    // reset overrides every other input
    vecs.push_back('{1'b1, 1'b1, 1'b1, 32'h84,       1'b1, 32'h0000_0000, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].trap);
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_mis);
    end

    // Long stall in HOLD: PC and pending target must survive unchanged
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_all("long pre", 32'h4, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    check_all("long capture", 32'h4, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      apply(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEC, 1'b0);
      check_all($sformatf("long hold%0d", k), 32'h4, 1'b1, 1'b0);
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_all("long release", 32'h200, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_all("long after", 32'h204, 1'b0, 1'b0);

    // Misaligned target delivered on the release cycle of a HOLD
    apply(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
    check_all("rel capture", 32'h204, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 32'h403, 1'b0);
    check_all("rel misalign", 32'h400, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_all("rel stall", 32'h400, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
